// File: rtl/regfile_scoreboard.sv
// Decode-stage integer register file with bypass, x0 = 0,
// post-reset clearing sequencer and per-register pending scoreboard.
module regfile_scoreboard #(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int NUM_READ = 2,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     ready,
  input  logic [NUM_READ*AW-1:0]   rs_address,
  output logic [NUM_READ*XLEN-1:0] rs_data,
  output logic [NUM_READ-1:0]      rs_pending,
  input  logic                     issue_valid,
  input  logic [AW-1:0]            issue_address,
  input  logic [AW-1:0]            rd_address,
  input  logic [XLEN-1:0]          rd_data,
  input  logic [AW-1:0]            bypass_address,
  input  logic [XLEN-1:0]          bypass_data
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  state_t          state;
  logic [AW-1:0]   idx;
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_nxt;
  logic [XLEN-1:0] regs [NREGS];

  always_comb begin
    pend_nxt = pend;
    if (rd_address != '0)
      pend_nxt[rd_address] = 1'b0;
    // a new producer issued this cycle outranks the retiring one
    if (issue_valid && issue_address != '0)
      pend_nxt[issue_address] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      idx   <= AW'(1);
      ready <= 1'b0;
      pend  <= '0;
    end else begin
      unique case (state)
        INIT: begin
          if (idx == LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        RUN: pend <= pend_nxt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT)
        regs[idx] <= '0;
      else if (rd_address != '0)
        regs[rd_address] <= rd_data;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            hit_byp;
    logic            hit_rd;

    assign a       = rs_address[i*AW +: AW];
    assign hit_byp = (a == bypass_address);
    assign hit_rd  = (a == rd_address);

    always_comb begin
      d = '0;
      if (!ready || a == '0)
        d = '0;
      else if (hit_byp)
        d = bypass_data;
      else if (hit_rd)
        d = rd_data;
      else
        d = regs[a];
    end

    assign rs_data[i*XLEN +: XLEN] = d;
    assign rs_pending[i] = ready && pend[a] && (a != '0)
                           && !hit_byp && !hit_rd;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard,
// default (32x32, 2 ports) and small (8 regs, 3 ports) variants.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ready;
  logic [9:0]  rs_address = '0;
  logic [63:0] rs_data;
  logic [1:0]  rs_pending;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_address = '0;
  logic [4:0]  rd_address = '0;
  logic [31:0] rd_data = '0;
  logic [4:0]  bypass_address = '0;
  logic [31:0] bypass_data = '0;

  logic        s_reset = 1'b1;
  logic        s_ready;
  logic [8:0]  s_rs_address = '0;
  logic [95:0] s_rs_data;
  logic [2:0]  s_rs_pending;
  logic        s_issue_valid = 1'b0;
  logic [2:0]  s_issue_address = '0;
  logic [2:0]  s_rd_address = '0;
  logic [31:0] s_rd_data = '0;
  logic [2:0]  s_bypass_address = '0;
  logic [31:0] s_bypass_data = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_scoreboard u_dut (
    .clk(clk), .reset(reset), .ready(ready),
    .rs_address(rs_address), .rs_data(rs_data),
    .rs_pending(rs_pending),
    .issue_valid(issue_valid), .issue_address(issue_address),
    .rd_address(rd_address), .rd_data(rd_data),
    .bypass_address(bypass_address), .bypass_data(bypass_data)
  );

  regfile_scoreboard #(.XLEN(32), .NREGS(8), .NUM_READ(3)) u_small (
    .clk(clk), .reset(s_reset), .ready(s_ready),
    .rs_address(s_rs_address), .rs_data(s_rs_data),
    .rs_pending(s_rs_pending),
    .issue_valid(s_issue_valid), .issue_address(s_issue_address),
    .rd_address(s_rd_address), .rd_data(s_rd_data),
    .bypass_address(s_bypass_address), .bypass_data(s_bypass_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b want 0", ready);
    end
    rs_address = {5'd3, 5'd17};
    #1;
    checks++;
    if (rs_data !== 64'h0 || rs_pending !== 2'b00) begin
      errors++;
      $display("FAIL init_read got %h/%b want 0/0", rs_data, rs_pending);
    end
    wait_ready(n);
    checks++;
    if (n !== 31) begin
      errors++;
      $display("FAIL ready_latency got %0d want 31", n);
    end
    for (int r = 0; r < 32; r += 2) begin
      rs_address = {5'(r + 1), 5'(r)};
      #1;
      checks++;
      if (rs_data !== 64'h0 || rs_pending !== 2'b00) begin
        errors++;
        $display("FAIL clear_x%0d got %h want 0", r, rs_data);
      end
    end
  endtask

  task automatic test_write_read();
    rd_address = 5'd5;
    rd_data    = 32'hDEADBEEF;
    step();
    rd_address = 5'd0;
    rd_data    = 32'h1234;
    rs_address = {5'd0, 5'd5};
    #1;
    checks++;
    if (rs_data[31:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_x5 got %h want deadbeef", rs_data[31:0]);
    end
    checks++;
    if (rs_data[63:32] !== 32'h0) begin
      errors++;
      $display("FAIL rd_x0 got %h want 0", rs_data[63:32]);
    end
  endtask

  task automatic test_bypass();
    rd_address = 5'd7;
    rd_data    = 32'h1;
    step();
    rd_data        = 32'h5555;
    bypass_address = 5'd7;
    bypass_data    = 32'hAAAA0000;
    rs_address     = {5'd7, 5'd7};
    #1;
    checks++;
    if (rs_data !== {2{32'hAAAA0000}}) begin
      errors++;
      $display("FAIL byp_prio got %h want aaaa0000 x2", rs_data);
    end
    bypass_address = 5'd0;
    #1;
    checks++;
    if (rs_data[31:0] !== 32'h5555) begin
      errors++;
      $display("FAIL rd_fwd got %h want 5555", rs_data[31:0]);
    end
    rd_address = 5'd0;
    #1;
    checks++;
    if (rs_data[31:0] !== 32'h1) begin
      errors++;
      $display("FAIL reg_x7 got %h want 1", rs_data[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    issue_valid   = 1'b1;
    issue_address = 5'd9;
    step();
    issue_valid = 1'b0;
    rs_address  = {5'd5, 5'd9};
    #1;
    checks++;
    if (rs_pending !== 2'b01) begin
      errors++;
      $display("FAIL pend_set got %b want 01", rs_pending);
    end
    bypass_address = 5'd9;
    bypass_data    = 32'h77;
    #1;
    checks++;
    if (rs_pending !== 2'b00 || rs_data[31:0] !== 32'h77) begin
      errors++;
      $display("FAIL pend_byp got %b/%h want 00/77",
               rs_pending, rs_data[31:0]);
    end
    bypass_address = 5'd0;
    rd_address     = 5'd9;
    rd_data        = 32'h99;
    #1;
    checks++;
    if (rs_pending !== 2'b00) begin
      errors++;
      $display("FAIL pend_rdfwd got %b want 00", rs_pending);
    end
    step();
    rd_address = 5'd0;
    #1;
    checks++;
    if (rs_pending !== 2'b00 || rs_data[31:0] !== 32'h99) begin
      errors++;
      $display("FAIL pend_clr got %b/%h want 00/99",
               rs_pending, rs_data[31:0]);
    end
  endtask

  task automatic test_set_wins();
    issue_valid   = 1'b1;
    issue_address = 5'd3;
    rd_address    = 5'd3;
    rd_data       = 32'h33;
    step();
    issue_valid = 1'b0;
    rd_address  = 5'd0;
    rs_address  = {5'd3, 5'd3};
    #1;
    checks++;
    if (rs_pending !== 2'b11) begin
      errors++;
      $display("FAIL set_wins got %b want 11", rs_pending);
    end
    rd_address = 5'd3;
    step();
    rd_address = 5'd0;
    #1;
    checks++;
    if (rs_pending !== 2'b00) begin
      errors++;
      $display("FAIL x3_retire got %b want 00", rs_pending);
    end
  endtask

  task automatic test_reset_restart();
    int n;
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_ready(n);
    checks++;
    if (n !== 31) begin
      errors++;
      $display("FAIL midinit_latency got %0d want 31", n);
    end
    rd_address    = 5'd4;
    rd_data       = 32'h44;
    issue_valid   = 1'b1;
    issue_address = 5'd4;
    step();
    rd_address  = 5'd0;
    issue_valid = 1'b0;
    rs_address  = {5'd4, 5'd4};
    #1;
    checks++;
    if (rs_pending !== 2'b11 || rs_data[31:0] !== 32'h44) begin
      errors++;
      $display("FAIL x4_pend got %b/%h want 11/44",
               rs_pending, rs_data[31:0]);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_ready(n);
    checks++;
    if (n !== 31) begin
      errors++;
      $display("FAIL run_reset_latency got %0d want 31", n);
    end
    checks++;
    if (rs_pending !== 2'b00 || rs_data !== 64'h0) begin
      errors++;
      $display("FAIL x4_cleared got %b/%h want 00/0",
               rs_pending, rs_data);
    end
  endtask

  task automatic test_small();
    int n;
    s_reset = 1'b1;
    step();
    s_reset = 1'b0;
    n = 0;
    while (!s_ready && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n !== 7) begin
      errors++;
      $display("FAIL small_latency got %0d want 7", n);
    end
    s_rs_address = {3'd7, 3'd6, 3'd1};
    #1;
    checks++;
    if (s_rs_data !== 96'h0) begin
      errors++;
      $display("FAIL small_clear got %h want 0", s_rs_data);
    end
    s_rd_address = 3'd5;
    s_rd_data    = 32'hCAFE0005;
    step();
    s_rd_address = 3'd0;
    s_rs_address = {3'd5, 3'd0, 3'd5};
    #1;
    checks++;
    if (s_rs_data !== {32'hCAFE0005, 32'h0, 32'hCAFE0005}) begin
      errors++;
      $display("FAIL small_wr got %h want cafe0005/0/cafe0005",
               s_rs_data);
    end
    s_rd_address     = 3'd6;
    s_rd_data        = 32'h5555;
    s_bypass_address = 3'd6;
    s_bypass_data    = 32'hAAAA0000;
    s_rs_address     = {3'd5, 3'd6, 3'd0};
    #1;
    checks++;
    if (s_rs_data[63:32] !== 32'hAAAA0000) begin
      errors++;
      $display("FAIL small_byp got %h want aaaa0000",
               s_rs_data[63:32]);
    end
    s_bypass_address = 3'd0;
    #1;
    checks++;
    if (s_rs_data[63:32] !== 32'h5555) begin
      errors++;
      $display("FAIL small_rdfwd got %h want 5555", s_rs_data[63:32]);
    end
    s_rd_address = 3'd0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_set_wins();
    test_reset_restart();
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
